// File: rtl/dmem_pkg.sv
// Shared types for the data-memory controller: FSM states, access size codes,
// and byte-enable generation.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic [3:0] be_gen(
        input logic [1:0] sz,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (sz)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select plus sign/zero extension of the memory response.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [31:0] sh;

    always_comb begin
        sh   = rdata >> {off, 3'b000};
        data = rdata;
        unique case (size)
            SZ_BYTE: data = uns ? {24'h0, sh[7:0]}
                                : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: data = uns ? {16'h0, sh[15:0]}
                                : {{16{sh[15]}}, sh[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller with req/gnt/rvalid port and datapath stall.
// Byte/half accesses are built only when DMEM_CTRL_SUBWORD_EN is defined.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              stall,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              we_q;
    logic              err_q;

    logic              access;
    logic              bad;
    logic [31:0]       wd_al;
    logic [3:0]        be_al;
    logic [31:0]       ld_data;

`ifdef DMEM_CTRL_SUBWORD_EN
    logic [1:0] size_q;
    logic       uns_q;
    logic       misal;

    always_comb begin
        misal = ((size == SZ_HALF) & addr[0])
              | ((size == SZ_WORD) & (addr[1:0] != 2'b00));
        bad   = (mem_read & mem_write) | (size == 2'b11) | misal;
        be_al = be_gen(size, addr[1:0]);
        unique case (size)
            SZ_BYTE: wd_al = {4{write_data[7:0]}};
            SZ_HALF: wd_al = {2{write_data[15:0]}};
            default: wd_al = write_data;
        endcase
    end

    load_align u_align (
        .rdata (mem_rdata),
        .off   (addr_q[1:0]),
        .size  (size_q),
        .uns   (uns_q),
        .data  (ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            size_q <= SZ_WORD;
            uns_q  <= 1'b0;
        end else if (state == IDLE && access) begin
            size_q <= size;
            uns_q  <= unsigned_ld;
        end
    end
`else
    // Word-only build: size/unsigned_ld and the low address bits of the
    // latched address have no consumer.
    logic unused_cfg;
    assign unused_cfg = ^{size, unsigned_ld, addr_q[1:0]};

    assign bad     = (mem_read & mem_write) | (addr[1:0] != 2'b00);
    assign be_al   = 4'b1111;
    assign wd_al   = write_data;
    assign ld_data = mem_rdata;
`endif

    assign access = mem_read | mem_write;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (access) state_n = bad ? DONE : REQ;
            REQ:  if (mem_gnt) state_n = we_q ? DONE : WAIT;
            WAIT: if (mem_rvalid) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            read_data <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && access) begin
                addr_q  <= addr;
                wdata_q <= wd_al;
                be_q    <= be_al;
                we_q    <= mem_write;
                err_q   <= bad;
                if (bad) read_data <= '0;
            end
            if (state == WAIT && mem_rvalid) read_data <= ld_data;
        end
    end

    assign mem_req   = (state == REQ);
    assign mem_we    = we_q & mem_req;
    assign mem_addr  = addr_q[ADDR_W-1:2];
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign err       = (state == DONE) & err_q;
    assign stall     = ((state == IDLE) & access)
                     | (state == REQ) | (state == WAIT);

endmodule
